// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one UART transmit serializer among NUM_REQ
// byte requesters. It grants one requester at a time and latches that requester's byte and
// parity. It holds send until the serializer reports active, then waits for the frame to end.
// It returns a per-requester done pulse and inserts an idle gap before the next grant.
//
// Ports:
//   baud_clk    baud-rate clock shared with the serializer
//   rst         synchronous active-high reset
//   req         level request per requester
//   req_data    byte of requester i at [8i+7:8i]
//   req_ack     one-hot pulse: byte latched, requester may release
//   req_done    one-hot pulse: that requester's frame fully transmitted
//   tx_send     serializer send strobe (held until tx_active is seen)
//   tx_data     serializer data, stable for the whole frame
//   tx_parity   serializer parity bit
//   tx_active   serializer active flag
//   tx_done     serializer done flag (sticky, not used for sequencing)
//   busy        high whenever the scheduler is not idle
//   cur_id      index of the current or last granted requester
//   err_timeout pulse when the serializer never went active after send
module uart_tx_sched #(
  parameter int unsigned NUM_REQ       = 4,
  parameter bit          PARITY_ODD    = 1'b0,
  parameter int unsigned START_TIMEOUT = 4,
  parameter int unsigned GAP_CYCLES    = 1
) (
  input  logic                       baud_clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ack,
  output logic [NUM_REQ-1:0]         req_done,
  output logic                       tx_send,
  output logic [7:0]                 tx_data,
  output logic                       tx_parity,
  input  logic                       tx_active,
  input  logic                       tx_done,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] cur_id,
  output logic                       err_timeout
);

  localparam int unsigned IdW  = $clog2(NUM_REQ);
  localparam int unsigned CntW = 16;

  typedef enum logic [1:0] {StIdle, StSend, StBusy, StGap} state_e;

  state_e             state_q, state_d;
  logic [IdW-1:0]     ptr_q, ptr_d;
  logic [IdW-1:0]     cur_id_q, cur_id_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_parity_q, tx_parity_d;
  logic [CntW-1:0]    to_cnt_q, to_cnt_d;
  logic [CntW-1:0]    gap_cnt_q, gap_cnt_d;
  logic [NUM_REQ-1:0] req_ack_q, req_ack_d;
  logic [NUM_REQ-1:0] req_done_q, req_done_d;
  logic               err_timeout_q, err_timeout_d;

  logic               grant_found;
  logic [IdW-1:0]     grant_idx;
  logic [IdW-1:0]     cand_id;
  int unsigned        cand;
  logic [7:0]         grant_byte;

  // tx_done stays high from the previous frame, so sequencing relies on tx_active only.
  logic unused_tx_done;
  assign unused_tx_done = tx_done;

  // First requesting index at or above the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_id     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cand_id = IdW'(cand);
      if (!grant_found && req[cand_id]) begin
        grant_found = 1'b1;
        grant_idx   = cand_id;
      end
    end
  end

  always_comb begin
    grant_byte = 8'h00;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (IdW'(i) == grant_idx) begin
        grant_byte = req_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cur_id_d      = cur_id_q;
    tx_data_d     = tx_data_q;
    tx_parity_d   = tx_parity_q;
    to_cnt_d      = to_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    req_ack_d     = '0;
    req_done_d    = '0;
    err_timeout_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (grant_found) begin
          cur_id_d    = grant_idx;
          tx_data_d   = grant_byte;
          tx_parity_d = (^grant_byte) ^ PARITY_ODD;
          req_ack_d   = NUM_REQ'(1) << grant_idx;
          ptr_d       = (grant_idx == IdW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
          to_cnt_d    = '0;
          state_d     = StSend;
        end
      end
      StSend: begin
        if (tx_active) begin
          state_d = StBusy;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
          // Serializer never started: give up without reporting completion.
          if (to_cnt_d == CntW'(START_TIMEOUT)) begin
            err_timeout_d = 1'b1;
            state_d       = StIdle;
          end
        end
      end
      StBusy: begin
        if (!tx_active) begin
          req_done_d = NUM_REQ'(1) << cur_id_q;
          gap_cnt_d  = '0;
          state_d    = StGap;
        end
      end
      StGap: begin
        if ((GAP_CYCLES == 0) || (gap_cnt_q == CntW'(GAP_CYCLES - 1))) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge baud_clk) begin
    if (rst) begin
      state_q       <= StIdle;
      ptr_q         <= '0;
      cur_id_q      <= '0;
      tx_data_q     <= 8'h00;
      tx_parity_q   <= 1'b0;
      to_cnt_q      <= '0;
      gap_cnt_q     <= '0;
      req_ack_q     <= '0;
      req_done_q    <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cur_id_q      <= cur_id_d;
      tx_data_q     <= tx_data_d;
      tx_parity_q   <= tx_parity_d;
      to_cnt_q      <= to_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      req_ack_q     <= req_ack_d;
      req_done_q    <= req_done_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign tx_send     = (state_q == StSend);
  assign busy        = (state_q != StIdle);
  assign tx_data     = tx_data_q;
  assign tx_parity   = tx_parity_q;
  assign cur_id      = cur_id_q;
  assign req_ack     = req_ack_q;
  assign req_done    = req_done_q;
  assign err_timeout = err_timeout_q;

endmodule
